sample_voice_scheduler: RTL
===========================

# sample_voice_scheduler

Time-multiplexes one single-port sample BRAM read port across `NUM_VOICES` playback voices. On each `sample_tick_in` it sweeps the voices in fixed order 0..N-1, issues one BRAM read per voice, and captures the returned samples. It keeps a per-voice wrapping playback address, gated by each voice's `gate_in` bit. It sits between the note/gate logic and the mixer, replacing one address counter per voice with a single shared, scheduled read path.

## Interface
- `NUM_VOICES`, 4, number of voices sharing the BRAM port (≥1)
- `BRAM_DEPTH`, 8192, samples in the BRAM; addresses wrap at `BRAM_DEPTH-1`
- `ADDR_WIDTH`, 13, BRAM address width, `$clog2(BRAM_DEPTH)`
- `DATA_WIDTH`, 16, sample width (signed, passed through unmodified)
- `READ_LATENCY`, 2, cycles from address presented to data valid on `bram_data_in` (≥1)

Ports:
- `clk_in`  input  1  system clock; all state changes on rising edge
- `rst_in`  input  1  asynchronous, active-low reset
- `sample_tick_in`  input  1  one-cycle pulse per audio sample period
- `gate_in`  input  NUM_VOICES  per-voice gate; bit v high = voice v playing
- `bram_addr_out`  output  ADDR_WIDTH  BRAM read address (registered)
- `bram_data_in`  input  DATA_WIDTH  BRAM read data, valid `READ_LATENCY` cycles after address
- `voice_sample_out`  output  NUM_VOICES*DATA_WIDTH  captured samples; voice v at bits `[v*DATA_WIDTH +: DATA_WIDTH]`
- `sample_valid_out`  output  1  one-cycle pulse when all voices in `voice_sample_out` are updated
- `busy_out`  output  1  high whenever state ≠ IDLE
- `overrun_out`  output  1  one-cycle pulse when a tick arrives while busy

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `sample_tick_in`: snapshot `gate_in` into `gate_snap`, set voice index k=0, go to ISSUE.
  - `bram_addr_out` holds its last value.
- **ISSUE**, lasting `NUM_VOICES` cycles
  - Cycle k: `bram_addr_out` = `addr[k]` for voice k.
  - At the end of cycle k: if `gate_snap[k]`, `addr[k]` increments, wrapping `BRAM_DEPTH-1` to 0.
  - After k = N-1, go to DRAIN.
- **DRAIN**, lasting `READ_LATENCY` cycles
  - No new addresses are issued; in-flight reads complete.
  - Then go to DONE.
- **Capture**
  - A delay line of depth `READ_LATENCY` carries (valid, voice index, `gate_snap` bit) alongside each issued address.
  - When an entry emerges: if its gate bit is 1, write `bram_data_in` to that voice's slot; if 0, write 0 to that slot.
- **DONE**, one cycle
  - `sample_valid_out` = 1, then return to IDLE.
- **Gate low**
  - Any cycle where `gate_in[v]`=0 clears `addr[v]` to 0 at that edge.
  - The clear has priority over an increment in the same cycle.
  - A sample already snapshotted as gated still reads the pre-clear address.
- **Tick while busy** (ISSUE, DRAIN, or DONE)
  - The tick is dropped and `overrun_out` pulses for one cycle.
  - The sweep in progress is unaffected.
- Address arithmetic is unsigned `ADDR_WIDTH`, compared against `BRAM_DEPTH-1`. This is correct for non-power-of-2 depths.

## Timing
- **Reset** (`rst_in`=0, asynchronous)
  - State = IDLE.
  - All `addr[v]` = 0, `bram_addr_out` = 0, `voice_sample_out` = 0.
  - `sample_valid_out` = `busy_out` = `overrun_out` = 0.
  - Delay-line valids are cleared.
- **Reset mid-sweep**: the sweep is aborted, no `sample_valid_out` is produced, and the outputs take their reset values.
- **Sweep latency**: tick sampled at cycle T.
  - Voice k's address is on `bram_addr_out` during cycle T+1+k.
  - Voice k's data is captured at the end of cycle T+1+k+`READ_LATENCY`.
  - `sample_valid_out` is high in cycle T+N+`READ_LATENCY`+1.
  - `busy_out` is high from T+1 through T+N+`READ_LATENCY`+1.
- **Minimum tick spacing** without overrun: N+`READ_LATENCY`+2 cycles. With defaults that is 8.
- `voice_sample_out` slots change only at capture edges and hold between sweeps.

## Test plan
- **Reset values**: hold `rst_in`=0, then release.
  - Expect all outputs 0 and `busy_out`=0.
  - Assert `rst_in`=0 mid-ISSUE: expect outputs 0 immediately (asynchronously) and no `sample_valid_out`.
- **Basic sweep**: BRAM model returns data = addr+0x100, `gate_in`=4'b1111, single tick at cycle T.
  - Expect addresses 0,0,0,0 at T+1..T+4.
  - Expect all voice slots = 0x0100.
  - Expect `sample_valid_out` at T+7.
  - A second tick yields all slots = 0x0101.
- **Gating**: `gate_in`=4'b0101 over 3 ticks.
  - Expect voices 0 and 2 at 0x0102 after the third sweep.
  - Expect voices 1 and 3 slots = 0 and their `addr` = 0.
  - Drop `gate_in[0]`, then raise it: voice 0 restarts at sample 0x0100.
- **Wrap-around**: `BRAM_DEPTH`=8, gate voice 0 for 9 ticks.
  - Expect voice 0 addresses 0..7 then 0; the 9th sample is 0x0100.
- **Overrun**: tick at T and T+3.
  - Expect `overrun_out` pulse at T+4 (the cycle after the tick sampled in ISSUE).
  - Expect only one `sample_valid_out` and addresses advanced by exactly 1.
- **Simultaneous events**: `gate_in[2]` falls in the same cycle voice 2 is issued.
  - Expect the read at the old address and the captured sample to be nonzero.
  - Expect `addr[2]`=0 afterwards (clear beats increment).

Source files
------------

// File: rtl/sample_voice_scheduler.sv
// sample_voice_scheduler
// Shares one single-port sample BRAM read port between NUM_VOICES playback
// voices. Each sample tick sweeps the voices in order 0..N-1, issues one read
// per voice from its private wrapping playback address, and captures the
// returned samples once the BRAM read latency has elapsed.
module sample_voice_scheduler #(
    parameter int NUM_VOICES   = 4,
    parameter int BRAM_DEPTH   = 8192,
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             sample_tick_in,
    input  logic [NUM_VOICES-1:0]            gate_in,
    output logic [ADDR_WIDTH-1:0]            bram_addr_out,
    input  logic [DATA_WIDTH-1:0]            bram_data_in,
    output logic [NUM_VOICES*DATA_WIDTH-1:0] voice_sample_out,
    output logic                             sample_valid_out,
    output logic                             busy_out,
    output logic                             overrun_out
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [IDX_W-1:0]      LAST_VOICE = IDX_W'(NUM_VOICES - 1);
    localparam logic [CNT_W-1:0]      LAST_DRAIN = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BRAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        voice_idx;
    logic [IDX_W-1:0]        next_idx;
    logic [CNT_W-1:0]        drain_cnt;
    logic [NUM_VOICES-1:0]   gate_snap;
    logic [ADDR_WIDTH-1:0]   addr [NUM_VOICES];

    // Read-return tracking: stage j holds the read issued j+1 cycles earlier,
    // so the last stage lines up with the data the BRAM is returning now.
    logic                    vld_p  [READ_LATENCY];
    logic [IDX_W-1:0]        idx_p  [READ_LATENCY];
    logic                    gate_p [READ_LATENCY];

    logic signed [DATA_WIDTH-1:0] bram_sample;

    // Next playback address; compares against the last valid address so that
    // non-power-of-2 depths wrap correctly.
    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    // Ungated voices deliver silence instead of whatever the BRAM returned.
    function automatic logic signed [DATA_WIDTH-1:0] gated_sample(
        input logic                         gate,
        input logic signed [DATA_WIDTH-1:0] d
    );
        return gate ? d : '0;
    endfunction

    assign next_idx    = voice_idx + IDX_W'(1);
    assign bram_sample = bram_data_in;

    // Sweep sequencer: IDLE -> ISSUE (one cycle per voice) -> DRAIN -> DONE.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            voice_idx        <= '0;
            drain_cnt        <= '0;
            gate_snap        <= '0;
            bram_addr_out    <= '0;
            sample_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            overrun_out      <= sample_tick_in && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_tick_in) begin
                        gate_snap     <= gate_in;
                        voice_idx     <= '0;
                        bram_addr_out <= addr[0];
                        busy_out      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (voice_idx == LAST_VOICE) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        voice_idx     <= next_idx;
                        bram_addr_out <= addr[next_idx];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        sample_valid_out <= 1'b1;
                        state            <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-voice playback addresses: a low gate clears, and wins over the
    // increment that follows the voice's own issue slot.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                addr[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (!gate_in[v]) begin
                    addr[v] <= '0;
                end else if (state == ISSUE && voice_idx == IDX_W'(v) && gate_snap[v]) begin
                    addr[v] <= wrap_inc(addr[v]);
                end
            end
        end
    end

    // Valid bits of the read-return delay line.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int j = 0; j < READ_LATENCY; j++) begin
                vld_p[j] <= 1'b0;
            end
        end else begin
            vld_p[0] <= (state == ISSUE);
            for (int j = 1; j < READ_LATENCY; j++) begin
                vld_p[j] <= vld_p[j-1];
            end
        end
    end

    // Voice index and gate bit travelling alongside each in-flight read.
    always_ff @(posedge clk_in) begin
        idx_p[0]  <= voice_idx;
        gate_p[0] <= gate_snap[voice_idx];
        for (int j = 1; j < READ_LATENCY; j++) begin
            idx_p[j]  <= idx_p[j-1];
            gate_p[j] <= gate_p[j-1];
        end
    end

    // Capture the returning sample into its voice slot; slots hold otherwise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            voice_sample_out <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (vld_p[READ_LATENCY-1] && idx_p[READ_LATENCY-1] == IDX_W'(v)) begin
                    voice_sample_out[v*DATA_WIDTH +: DATA_WIDTH] <=
                        gated_sample(gate_p[READ_LATENCY-1], bram_sample);
                end
            end
        end
    end

endmodule
